uart_tx_fifo: RTL and testbench

//  Parametrised serial transmitter. Replaces the single-word, level-enabled TX.
//  - Adds a valid/ready write port, a FIFO_DEPTH-word buffer, configurable data width and stop bits.
//  - Adds optional parity.
//  - Sits between game-logic producers and the board serial pin. Frames are sent LSB-first, back-to-back while the FIFO is non-empty.
//

---
 rtl/uart_tx_fifo_if.sv | 17 +
 rtl/uart_tx_fifo.sv | 214 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if -- valid/ready write port of the buffered UART transmitter.
//
//   i_data   producer -> TX   word to transmit
//   i_valid  producer -> TX   i_data valid this cycle
//   o_ready  TX -> producer   FIFO can accept; a write happens on i_valid & o_ready
//
// Modports: master (producer side), slave (transmitter side).
interface uart_tx_fifo_if #(
   parameter int DATA_BITS = 16
);
   logic [DATA_BITS-1:0] i_data;
   logic                 i_valid;
   logic                 o_ready;

   modport master (output i_data, output i_valid, input o_ready);
   modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- parametrised serial transmitter with a FIFO_DEPTH-word buffer.
// Frames go out LSB-first: start(0), DATA_BITS payload bits, optional parity,
// STOP_BITS stop bits(1). Frames run back-to-back while the FIFO holds words.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset (aborts any frame, empties FIFO)
//   bus           uart_tx_fifo_if.slave: i_data / i_valid / o_ready write port
//   s_out         serial line, idle high, registered
//   o_busy        high while a frame is on the line
//   o_fifo_count  words currently buffered
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the
// payload (even parity when PARITY_ODD=0, odd when PARITY_ODD=1).
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 5,
   parameter int DATA_BITS    = 16,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4,
   parameter int PARITY_ODD   = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   uart_tx_fifo_if.slave                 bus,
   output logic                          s_out,
   output logic                          o_busy,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int TICK_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W  = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
   localparam logic [0:0]        STOP_LAST = 1'(STOP_BITS - 1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd3;
`endif
   localparam logic [2:0] ST_STOP   = 3'd4;

   // Elaboration-time parameter legality checks.
   if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 16) begin : g_bad_db
      $error("uart_tx_fifo: DATA_BITS must be 5..16");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two in 2..16");
   end
   if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
      $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
   end

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     count;

   logic [2:0]           state;
   logic [TICK_W-1:0]    tick;
   logic [IDX_W-1:0]     bit_idx;
   logic [0:0]           stop_idx;
   logic [DATA_BITS-1:0] shreg;
`ifdef UART_TX_PARITY_EN
   logic                 parity_bit;
`endif

   logic push;
   logic pop;
   logic bit_end;

   // Held low during reset so producers never write into a FIFO being cleared.
   assign bus.o_ready  = rst_n & (count < DEPTH_C);
   assign push         = bus.i_valid & bus.o_ready;
   assign bit_end      = (tick == TICK_LAST);
   assign o_busy       = (state != ST_IDLE);
   assign o_fifo_count = count;

   // Pop either from IDLE, or on the last cycle of the last stop bit so the
   // next start bit follows with no idle gap.
   always_comb begin
      pop = 1'b0;
      if (count != '0) begin
         if (state == ST_IDLE) begin
            pop = 1'b1;
         end else if (state == ST_STOP && bit_end && stop_idx == STOP_LAST) begin
            pop = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         tick     <= '0;
         bit_idx  <= '0;
         stop_idx <= '0;
         shreg    <= '0;
         s_out    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         if (state == ST_IDLE || bit_end) begin
            tick <= '0;
         end else begin
            tick <= tick + 1'b1;
         end

         if (pop) begin
            // Payload is captured here; later i_data changes cannot reach the line.
            shreg <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^mem[rd_ptr]) ^ 1'(PARITY_ODD);
`endif
            state <= ST_START;
            s_out <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  s_out <= 1'b1;
               end
               ST_START: begin
                  if (bit_end) begin
                     state   <= ST_DATA;
                     bit_idx <= '0;
                     s_out   <= shreg[0];
                     shreg   <= shreg >> 1;
                  end
               end
               ST_DATA: begin
                  if (bit_end) begin
                     if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state <= ST_PARITY;
                        s_out <= parity_bit;
`else
                        state    <= ST_STOP;
                        stop_idx <= '0;
                        s_out    <= 1'b1;
`endif
                     end else begin
                        bit_idx <= bit_idx + 1'b1;
                        s_out   <= shreg[0];
                        shreg   <= shreg >> 1;
                     end
                  end
               end
`ifdef UART_TX_PARITY_EN
               ST_PARITY: begin
                  if (bit_end) begin
                     state    <= ST_STOP;
                     stop_idx <= '0;
                     s_out    <= 1'b1;
                  end
               end
`endif
               ST_STOP: begin
                  if (bit_end) begin
                     if (stop_idx == STOP_LAST) begin
                        state <= ST_IDLE;
                        s_out <= 1'b1;
                     end else begin
                        stop_idx <= stop_idx + 1'b1;
                     end
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  s_out <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo -- scoreboard bench for uart_tx_fifo.
// dut0: CLKS_PER_BIT=5, DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4, PARITY_ODD=0
// dut1: same but STOP_BITS=2, PARITY_ODD=1
// Build with +define+UART_TX_PARITY_EN to exercise the parity bit.
module tb_uart_tx_fifo;

   localparam int CPB = 5;
   localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
   localparam int PB  = 1;
`else
   localparam int PB  = 0;
`endif
   localparam int FRAME0 = (1 + DB + PB + 1) * CPB;

   typedef struct {
      logic [7:0] data;
      bit         b2b;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       s_out0, s_out1;
   logic       busy0, busy1;
   logic [2:0] cnt0, cnt1;

   uart_tx_fifo_if #(.DATA_BITS(8)) bus0 ();
   uart_tx_fifo_if #(.DATA_BITS(8)) bus1 ();

   uart_tx_fifo #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
      .s_out(s_out0), .o_busy(busy0), .o_fifo_count(cnt0)
   );

   uart_tx_fifo #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(1)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
      .s_out(s_out1), .o_busy(busy1), .o_fifo_count(cnt1)
   );

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t q0[$];
   exp_t q1[$];
   bit   mon_en = 1'b0;
   bit   mon_act[2];

   logic [7:0] t2_d   [6] = '{8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
   bit         t2_rdy [6] = '{1, 1, 1, 1, 1, 0};
   logic [2:0] t2_cnt [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic line(input int sel);
      return (sel == 0) ? s_out0 : s_out1;
   endfunction

   // Monitor: on each start bit pop the expected word and check every bit
   // period sample-by-sample, plus the idle gap for back-to-back frames.
   task automatic monitor(input int sel);
      exp_t           e;
      int             gap;
      int             nb;
      int             qs;
      logic           b;
      logic [CPB-1:0] obs;
      logic [CPB-1:0] req;
      gap = 1000;
      forever begin
         @(negedge clk);
         if (!mon_en || line(sel) !== 1'b0) begin
            if (gap < 1000) gap++;
            continue;
         end
         mon_act[sel] = 1'b1;
         qs = (sel == 0) ? q0.size() : q1.size();
         chk($sformatf("s%0d_frame_expected", sel), qs > 0, 1);
         if (qs > 0) begin
            e = (sel == 0) ? q0.pop_front() : q1.pop_front();
            if (e.b2b) chk($sformatf("s%0d_%02h_gap", sel, e.data), gap, 0);
            nb = 1 + DB + PB + ((sel == 0) ? 1 : 2);
            for (int k = 0; k < nb; k++) begin
               if (k == 0)                   b = 1'b0;
               else if (k <= DB)             b = e.data[k-1];
               else if (PB == 1 && k == DB + 1) b = (^e.data) ^ (sel == 1);
               else                          b = 1'b1;
               for (int s = 0; s < CPB; s++) begin
                  if (!(k == 0 && s == 0)) @(negedge clk);
                  obs[s] = line(sel);
               end
               req = {CPB{b}};
               chk($sformatf("s%0d_%02h_bit%0d", sel, e.data, k), obs, req);
            end
         end
         gap = 0;
         mon_act[sel] = 1'b0;
      end
   endtask

   initial monitor(0);
   initial monitor(1);

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || mon_act[0] || mon_act[1] || busy0 || busy1)
             && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_drain"}, n < 3000, 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int bad;
      rst_n = 1'b0;
      bus0.i_valid = 1'b0; bus0.i_data = '0;
      bus1.i_valid = 1'b0; bus1.i_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_s_out", s_out0, 1);
      chk("rst_busy", busy0, 0);
      chk("rst_count", cnt0, 0);
      chk("rst_ready", bus0.o_ready, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", bus0.o_ready, 1);
      mon_en = 1'b1;

      // Test 1: single word, latency and busy length.
      bus0.i_data = 8'hA5; bus0.i_valid = 1'b1;
      q0.push_back('{data: 8'hA5, b2b: 1'b0});
      @(negedge clk);
      bus0.i_valid = 1'b0;
      chk("t1_count_after_push", cnt0, 1);
      chk("t1_line_still_high", s_out0, 1);
      chk("t1_busy_before_pop", busy0, 0);
      @(negedge clk);
      chk("t1_start_low", s_out0, 0);
      chk("t1_busy_after_pop", busy0, 1);
      chk("t1_count_after_pop", cnt0, 0);
      n = 1;
      while (busy0 && n < 200) begin
         @(negedge clk);
         if (busy0) n++;
      end
      chk("t1_busy_cycles", n, FRAME0);
      wait_idle("t1");

      // Test 2: burst of six; push+pop on the same edge keeps count, sixth dropped.
      for (int k = 0; k < 6; k++) begin
         bus0.i_data = t2_d[k]; bus0.i_valid = 1'b1;
         chk($sformatf("t2_ready%0d", k), bus0.o_ready, t2_rdy[k]);
         if (t2_rdy[k]) q0.push_back('{data: t2_d[k], b2b: (k != 0)});
         @(negedge clk);
         chk($sformatf("t2_count%0d", k), cnt0, t2_cnt[k]);
      end

      // Test 3: hold a write while full; accepted one edge after the frame-end pop.
      bus0.i_data = 8'h3C;
      n = 0;
      while (cnt0 != 3'd3 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t3_dip_cycle", n, FRAME0 - 4);
      chk("t3_dip_ready", bus0.o_ready, 1);
      q0.push_back('{data: 8'h3C, b2b: 1'b1});
      @(negedge clk);
      bus0.i_valid = 1'b0;
      chk("t3_count_refill", cnt0, 4);
      chk("t3_ready_full", bus0.o_ready, 0);
      wait_idle("t3");

      // Test 5: parity (even on dut0, odd on dut1).
      bus0.i_data = 8'h07; bus0.i_valid = 1'b1;
      bus1.i_data = 8'h07; bus1.i_valid = 1'b1;
      q0.push_back('{data: 8'h07, b2b: 1'b0});
      q1.push_back('{data: 8'h07, b2b: 1'b0});
      @(negedge clk);
      bus0.i_valid = 1'b0; bus1.i_valid = 1'b0;
      wait_idle("t5");

      // Test 6: two stop bits, back-to-back.
      bus1.i_data = 8'h96; bus1.i_valid = 1'b1;
      q1.push_back('{data: 8'h96, b2b: 1'b0});
      @(negedge clk);
      bus1.i_data = 8'h69;
      q1.push_back('{data: 8'h69, b2b: 1'b1});
      @(negedge clk);
      bus1.i_valid = 1'b0;
      wait_idle("t6");

      // Test 4: reset mid-DATA with three words queued.
      mon_en = 1'b0;
      bus0.i_valid = 1'b1;
      bus0.i_data = 8'hFF; @(negedge clk);
      bus0.i_data = 8'h11; @(negedge clk);
      bus0.i_data = 8'h22; @(negedge clk);
      bus0.i_data = 8'h33; @(negedge clk);
      bus0.i_valid = 1'b0;
      repeat (18) @(negedge clk);
      chk("t4_count_before", cnt0, 3);
      chk("t4_busy_before", busy0, 1);
      rst_n = 1'b0;
      #1;
      chk("t4_rst_s_out", s_out0, 1);
      chk("t4_rst_busy", busy0, 0);
      chk("t4_rst_count", cnt0, 0);
      chk("t4_rst_ready", bus0.o_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (s_out0 !== 1'b1 || busy0 !== 1'b0 || cnt0 !== 3'd0) bad++;
      end
      chk("t4_quiet_after_release", bad, 0);

      chk("sb0_empty", q0.size(), 0);
      chk("sb1_empty", q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
